// File: rtl/hpdcache_pkg.sv
// Shared HPDcache write-buffer types.
// Contents: wbuf_state_e, the 2-bit lifecycle state of one WBUF directory entry.
package hpdcache_pkg;

  // Entry lifecycle. The encoding is visible on state_o, so it must stay fixed.
  typedef enum logic [1:0] {
    WBUF_FREE = 2'b00,
    WBUF_OPEN = 2'b01,
    WBUF_PEND = 2'b10,
    WBUF_SENT = 2'b11
  } wbuf_state_e;

endpackage

// File: rtl/hpdcache_rrarb.sv
// Round-robin arbiter that picks the first requester at or after a rotating pointer.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   req_i         request vector (one bit per entry)
//   hs_i          a grant was accepted this cycle
//   hs_idx_i      index of the accepted grant; the pointer moves to hs_idx_i+1
//   gnt_o         one-hot grant, combinational from req_i and the pointer
//   gnt_idx_o     index of the granted requester (0 when nothing is granted)
module hpdcache_rrarb #(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N-1:0]     req_i,
  input  logic             hs_i,
  input  logic [IDX_W-1:0] hs_idx_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o
);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_ptr;
  logic [IDX_W-1:0] w_cand;
  logic             w_found;

  // The pointer moves in the handshake cycle itself, so the next grant can be
  // presented on the very next cycle. N is a power of two, so the sum wraps.
  always_comb begin
    w_ptr     = hs_i ? hs_idx_i + IDX_W'(1) : r_ptr;
    gnt_o     = '0;
    gnt_idx_o = '0;
    w_found   = 1'b0;
    w_cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_cand = w_ptr + IDX_W'(k);
      if (!w_found && req_i[w_cand]) begin
        w_found          = 1'b1;
        gnt_o[w_cand]    = 1'b1;
        gnt_idx_o        = w_cand;
      end
    end
  end

  // Pointer register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (hs_i) begin
      r_ptr <= hs_idx_i + IDX_W'(1);
    end
  end

endmodule

// File: rtl/hpdcache_wbuf_send_sched.sv
// Write-buffer send scheduler: per-entry FREE/OPEN/PEND/SENT lifecycle, ageing
// of OPEN entries, and round-robin issue of PEND entries to the NoC.
// Ports:
//   clk_i, rst_i                   clock, synchronous active-high reset
//   cfg_threshold_i                OPEN->PEND age threshold
//   cfg_rst_on_wr_i                a write to an OPEN entry clears its timer
//   flush_all_i                    promote every OPEN entry to PEND
//   alloc_i/alloc_idx_i            FREE->OPEN
//   write_i/write_idx_i            data merged into an OPEN entry
//   close_i/close_idx_i            force an OPEN entry to PEND
//   send_valid_o/send_idx_o        registered offer of a PEND entry
//   send_ready_i                   NoC accept
//   ack_i/ack_idx_i                memory ack, SENT->FREE
//   free_o/free_idx_o/empty_o      any FREE / lowest FREE index / all FREE
//   state_o                        per-entry state, entry i at [2i+1:2i]
module hpdcache_wbuf_send_sched
  import hpdcache_pkg::*;
#(
  parameter  int unsigned N_ENTRIES     = 4,
  parameter  int unsigned TIMECNT_WIDTH = 4,
  localparam int unsigned IDX_W         = $clog2(N_ENTRIES)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [TIMECNT_WIDTH-1:0] cfg_threshold_i,
  input  logic                     cfg_rst_on_wr_i,
  input  logic                     flush_all_i,
  input  logic                     alloc_i,
  input  logic [IDX_W-1:0]         alloc_idx_i,
  input  logic                     write_i,
  input  logic [IDX_W-1:0]         write_idx_i,
  input  logic                     close_i,
  input  logic [IDX_W-1:0]         close_idx_i,
  output logic                     send_valid_o,
  output logic [IDX_W-1:0]         send_idx_o,
  input  logic                     send_ready_i,
  input  logic                     ack_i,
  input  logic [IDX_W-1:0]         ack_idx_i,
  output logic                     free_o,
  output logic [IDX_W-1:0]         free_idx_o,
  output logic                     empty_o,
  output logic [2*N_ENTRIES-1:0]   state_o
);

  logic                 r_send_valid;
  logic [IDX_W-1:0]     r_send_idx;
  logic                 w_hs;
  logic [N_ENTRIES-1:0] w_hs_mask;
  logic [N_ENTRIES-1:0] w_free;
  logic [N_ENTRIES-1:0] w_open;
  logic [N_ENTRIES-1:0] w_pend;
  logic [N_ENTRIES-1:0] w_sent;
  logic [N_ENTRIES-1:0] w_gnt;
  logic [IDX_W-1:0]     w_gnt_idx;

  assign w_hs = r_send_valid && send_ready_i;

  // Per-entry lifecycle FSM and age timer
  for (genvar gi = 0; gi < N_ENTRIES; gi++) begin : g_entry
    wbuf_state_e              r_state;
    wbuf_state_e              w_state_nxt;
    logic [TIMECNT_WIDTH-1:0] r_timer;
    logic [TIMECNT_WIDTH-1:0] w_timer_nxt;
    logic                     w_alloc_hit;
    logic                     w_write_rst;
    logic                     w_close_hit;
    logic                     w_send_hit;
    logic                     w_ack_hit;

    assign w_alloc_hit = alloc_i && (alloc_idx_i == IDX_W'(gi));
    assign w_write_rst = write_i && cfg_rst_on_wr_i && (write_idx_i == IDX_W'(gi));
    assign w_close_hit = close_i && (close_idx_i == IDX_W'(gi));
    assign w_send_hit  = w_hs && (r_send_idx == IDX_W'(gi));
    assign w_ack_hit   = ack_i && (ack_idx_i == IDX_W'(gi));

    // Commands aimed at an entry in the wrong state fall through untouched.
    always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      case (r_state)
        WBUF_FREE: begin
          if (w_alloc_hit) begin
            w_state_nxt = WBUF_OPEN;
            w_timer_nxt = '0;
          end
        end
        WBUF_OPEN: begin
          // A resetting write masks the threshold compare; close/flush still win.
          w_timer_nxt = w_write_rst ? '0
                      : ((&r_timer) ? r_timer : r_timer + TIMECNT_WIDTH'(1));
          if (w_close_hit || flush_all_i ||
              (!w_write_rst && (r_timer >= cfg_threshold_i))) begin
            w_state_nxt = WBUF_PEND;
          end
        end
        WBUF_PEND: begin
          if (w_send_hit) w_state_nxt = WBUF_SENT;
        end
        WBUF_SENT: begin
          if (w_ack_hit) w_state_nxt = WBUF_FREE;
        end
        default: w_state_nxt = r_state;
      endcase
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_state <= WBUF_FREE;
        r_timer <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_timer <= w_timer_nxt;
      end
    end

    assign w_free[gi]         = (r_state == WBUF_FREE);
    assign w_open[gi]         = (r_state == WBUF_OPEN);
    assign w_pend[gi]         = (r_state == WBUF_PEND);
    assign w_sent[gi]         = (r_state == WBUF_SENT);
    assign state_o[2*gi +: 2] = r_state;
  end

  // The entry leaving PEND this cycle must not be re-granted.
  always_comb begin
    w_hs_mask = '0;
    if (w_hs) w_hs_mask[r_send_idx] = 1'b1;
  end

  hpdcache_rrarb #(
    .N (N_ENTRIES)
  ) u_rrarb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (w_pend & ~w_hs_mask),
    .hs_i      (w_hs),
    .hs_idx_i  (r_send_idx),
    .gnt_o     (w_gnt),
    .gnt_idx_o (w_gnt_idx)
  );

  // Offer register: holds (locks) the offered index until it is accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_send_valid <= 1'b0;
      r_send_idx   <= '0;
    end else if (!r_send_valid || send_ready_i) begin
      r_send_valid <= |w_gnt;
      if (|w_gnt) r_send_idx <= w_gnt_idx;
    end
  end

  assign send_valid_o = r_send_valid;
  assign send_idx_o   = r_send_idx;

  // Lowest FREE index, 0 when none
  always_comb begin
    free_idx_o = '0;
    for (int unsigned k = N_ENTRIES; k > 0; k--) begin
      if (w_free[IDX_W'(k-1)]) free_idx_o = IDX_W'(k-1);
    end
  end

  assign free_o  = |w_free;
  assign empty_o = &w_free;

`ifndef SYNTHESIS
  a_alloc_free: assert property (@(posedge clk_i) disable iff (rst_i)
    alloc_i |-> w_free[alloc_idx_i]) else $error("alloc to non-FREE entry");
  a_write_open: assert property (@(posedge clk_i) disable iff (rst_i)
    write_i |-> w_open[write_idx_i]) else $error("write to non-OPEN entry");
  a_close_open: assert property (@(posedge clk_i) disable iff (rst_i)
    close_i |-> w_open[close_idx_i]) else $error("close to non-OPEN entry");
  a_ack_sent: assert property (@(posedge clk_i) disable iff (rst_i)
    ack_i |-> w_sent[ack_idx_i]) else $error("ack to non-SENT entry");
`endif

endmodule

// File: tb/tb_hpdcache_wbuf_send_sched.sv
// Self-checking bench for hpdcache_wbuf_send_sched: directed scenarios plus
// randomized legal traffic against a behavioural model; accepted sends are
// checked by a scoreboard queue drained by an independent monitor.
module tb_hpdcache_wbuf_send_sched;

  localparam int N    = 4;
  localparam int TW   = 4;
  localparam int IW   = 2;
  localparam int TMAX = (1 << TW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [TW-1:0] thr;
  logic          rstwr, flush, alloc, write, close, ready, ack;
  logic [IW-1:0] aidx, widx, cidx, kidx;
  logic          send_valid_o, free_o, empty_o;
  logic [IW-1:0] send_idx_o, free_idx_o;
  logic [2*N-1:0] state_o;

  int errors = 0;
  int checks = 0;

  // Reference model: entry states (0 FREE,1 OPEN,2 PEND,3 SENT), ages, offer
  int m_st[N];
  int m_tm[N];
  int m_ptr;
  int m_li;
  bit m_lv;
  int exp_q[$];

  always #5 clk = ~clk;

  hpdcache_wbuf_send_sched #(.N_ENTRIES(N), .TIMECNT_WIDTH(TW)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .cfg_threshold_i (thr),
    .cfg_rst_on_wr_i (rstwr),
    .flush_all_i     (flush),
    .alloc_i         (alloc),
    .alloc_idx_i     (aidx),
    .write_i         (write),
    .write_idx_i     (widx),
    .close_i         (close),
    .close_idx_i     (cidx),
    .send_valid_o    (send_valid_o),
    .send_idx_o      (send_idx_o),
    .send_ready_i    (ready),
    .ack_i           (ack),
    .ack_idx_i       (kidx),
    .free_o          (free_o),
    .free_idx_o      (free_idx_o),
    .empty_o         (empty_o),
    .state_o         (state_o)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  function automatic void model_step();
    int nst[N];
    int ntm[N];
    bit hs;
    bit wr;
    bit found;
    int pe;
    int j;
    int nli;
    if (rst) begin
      for (int i = 0; i < N; i++) begin m_st[i] = 0; m_tm[i] = 0; end
      m_ptr = 0; m_lv = 1'b0; m_li = 0;
      return;
    end
    hs = m_lv && ready;
    for (int i = 0; i < N; i++) begin
      nst[i] = m_st[i];
      ntm[i] = m_tm[i];
      case (m_st[i])
        0: if (alloc && int'(aidx) == i) begin nst[i] = 1; ntm[i] = 0; end
        1: begin
          wr     = write && rstwr && int'(widx) == i;
          ntm[i] = wr ? 0 : ((m_tm[i] < TMAX) ? m_tm[i] + 1 : TMAX);
          if ((close && int'(cidx) == i) || flush || (!wr && m_tm[i] >= int'(thr)))
            nst[i] = 2;
        end
        2: if (hs && m_li == i) nst[i] = 3;
        default: if (ack && int'(kidx) == i) nst[i] = 0;
      endcase
    end
    if (hs) exp_q.push_back(m_li);
    if (!m_lv || ready) begin
      pe = hs ? (m_li + 1) % N : m_ptr;
      found = 1'b0;
      nli = 0;
      for (int k = 0; k < N; k++) begin
        j = (pe + k) % N;
        if (!found && m_st[j] == 2 && !(hs && j == m_li)) begin found = 1'b1; nli = j; end
      end
      if (hs) m_ptr = (m_li + 1) % N;
      m_lv = found;
      if (found) m_li = nli;
    end
    for (int i = 0; i < N; i++) begin m_st[i] = nst[i]; m_tm[i] = ntm[i]; end
  endfunction

  task automatic check_all();
    logic [2*N-1:0] es;
    bit ff;
    bit fe;
    int fi;
    ff = 1'b0; fe = 1'b1; fi = 0;
    for (int i = 0; i < N; i++) es[2*i +: 2] = 2'(m_st[i]);
    for (int i = N - 1; i >= 0; i--) begin
      if (m_st[i] == 0) begin ff = 1'b1; fi = i; end
      else fe = 1'b0;
    end
    chk("state_o", int'(state_o), int'(es));
    chk("send_valid_o", int'(send_valid_o), int'(m_lv));
    if (m_lv) chk("send_idx_o", int'(send_idx_o), m_li);
    chk("free_o", int'(free_o), int'(ff));
    chk("free_idx_o", int'(free_idx_o), fi);
    chk("empty_o", int'(empty_o), int'(fe));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0; alloc = 1'b0; write = 1'b0; close = 1'b0; flush = 1'b0; ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
  endtask

  function automatic int pick(input int s);
    int c[$];
    for (int i = 0; i < N; i++) if (m_st[i] == s) c.push_back(i);
    if (c.size() == 0) return -1;
    return c[$urandom_range(0, c.size() - 1)];
  endfunction

  // Monitor: every accepted send must match the oldest predicted send.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (!rst && send_valid_o && ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_send: got idx %0d expected none", send_idx_o);
        end else begin
          e = exp_q.pop_front();
          if (int'(send_idx_o) != e) begin
            errors++;
            $display("FAIL sb_send_idx: got %0d expected %0d", send_idx_o, e);
          end
        end
      end
    end
  end

  initial begin
    int i;
    rst = 1'b1; thr = 4'd3; rstwr = 1'b0; flush = 1'b0; ready = 1'b0;
    alloc = 1'b0; write = 1'b0; close = 1'b0; ack = 1'b0;
    aidx = '0; widx = '0; cidx = '0; kidx = '0;
    for (int k = 0; k < N; k++) begin m_st[k] = 0; m_tm[k] = 0; end
    m_ptr = 0; m_lv = 1'b0; m_li = 0;

    // Reset values
    do_reset();
    chk("rst_state", int'(state_o), 0);
    chk("rst_send_valid", int'(send_valid_o), 0);
    chk("rst_send_idx", int'(send_idx_o), 0);
    chk("rst_free", int'(free_o), 1);
    chk("rst_empty", int'(empty_o), 1);

    // Threshold ageing: alloc at t0 -> OPEN t1, PEND t5, offered t6
    thr = 4'd3; alloc = 1'b1; aidx = 2'd0; tick();
    chk("age_open_t1", int'(state_o[1:0]), 1);
    repeat (3) begin tick(); chk("age_open", int'(state_o[1:0]), 1); end
    tick();
    chk("age_pend_t5", int'(state_o[1:0]), 2);
    chk("age_novalid_t5", int'(send_valid_o), 0);
    tick();
    chk("age_valid_t6", int'(send_valid_o), 1);
    chk("age_idx_t6", int'(send_idx_o), 0);
    ready = 1'b1; tick();
    chk("age_sent", int'(state_o[1:0]), 3);
    ready = 1'b0; ack = 1'b1; kidx = 2'd0; tick();
    chk("age_acked", int'(state_o[1:0]), 0);

    // Timer reset on write keeps the entry OPEN; PEND 4 cycles after last write
    do_reset();
    thr = 4'd3; rstwr = 1'b1; alloc = 1'b1; aidx = 2'd0; tick();
    repeat (4) begin
      tick();
      write = 1'b1; widx = 2'd0; tick();
      chk("wr_keep_open", int'(state_o[1:0]), 1);
    end
    repeat (3) begin tick(); chk("wr_open_tail", int'(state_o[1:0]), 1); end
    tick();
    chk("wr_pend", int'(state_o[1:0]), 2);
    rstwr = 1'b0;

    // Offer lock, then wrap-around to idx1
    do_reset();
    thr = 4'd15;
    alloc = 1'b1; aidx = 2'd2; tick();
    alloc = 1'b1; aidx = 2'd1; tick();
    close = 1'b1; cidx = 2'd2; tick();
    tick();
    chk("lock_first_idx", int'(send_idx_o), 2);
    close = 1'b1; cidx = 2'd1; tick();
    repeat (4) begin tick(); chk("lock_hold_idx", int'(send_idx_o), 2); end
    ready = 1'b1; tick();
    chk("lock_sent2", int'(state_o[5:4]), 3);
    chk("lock_next_valid", int'(send_valid_o), 1);
    chk("lock_next_idx", int'(send_idx_o), 1);
    tick();
    ready = 1'b0;

    // Flush of 4 OPEN entries, round-robin 0..3 back to back, then ack idx3
    do_reset();
    thr = 4'd15;
    for (int k = 0; k < N; k++) begin alloc = 1'b1; aidx = 2'(k); tick(); end
    flush = 1'b1; tick();
    chk("flush_all_pend", int'(state_o), 8'hAA);
    ready = 1'b1; tick();
    chk("rr_idx0", int'(send_idx_o), 0);
    for (int g = 1; g < N; g++) begin tick(); chk("rr_idx", int'(send_idx_o), g); end
    tick();
    chk("rr_done_valid", int'(send_valid_o), 0);
    chk("rr_all_sent", int'(state_o), 8'hFF);
    chk("rr_not_empty", int'(empty_o), 0);
    ready = 1'b0; ack = 1'b1; kidx = 2'd3; tick();
    chk("ack3_free", int'(free_o), 1);
    chk("ack3_free_idx", int'(free_idx_o), 3);

    // Threshold 0 gives PEND at t+2; reset while offered but not accepted
    do_reset();
    thr = 4'd0; alloc = 1'b1; aidx = 2'd1; tick();
    tick();
    chk("thr0_pend", int'(state_o[3:2]), 2);
    tick();
    chk("pre_rst_valid", int'(send_valid_o), 1);
    rst = 1'b1; tick();
    chk("mid_rst_valid", int'(send_valid_o), 0);
    chk("mid_rst_state", int'(state_o), 0);
    chk("mid_rst_empty", int'(empty_o), 1);

    // Randomized legal traffic
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) begin
        thr   = 4'($urandom_range(0, 15));
        rstwr = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 3) == 0) begin
        i = pick(0);
        if (i >= 0) begin alloc = 1'b1; aidx = 2'(i); end
      end
      if ($urandom_range(0, 2) == 0) begin
        i = pick(1);
        if (i >= 0) begin write = 1'b1; widx = 2'(i); end
      end
      if ($urandom_range(0, 7) == 0) begin
        i = pick(1);
        if (i >= 0) begin close = 1'b1; cidx = 2'(i); end
      end
      if ($urandom_range(0, 2) == 0) begin
        i = pick(3);
        if (i >= 0) begin ack = 1'b1; kidx = 2'(i); end
      end
      flush = ($urandom_range(0, 39) == 0);
      ready = ($urandom_range(0, 2) != 0);
      rst   = ($urandom_range(0, 399) == 0);
      tick();
    end

    ready = 1'b0;
    tick();
    tick();
    chk("sb_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
